logic_tt_sequencer: RTL

//   Truth-table controller for a combinational logic-gate datapath.
//   On start, drives every input combination 0..2^N_IN-1 onto the gate inputs in turn.

---
 rtl/logic_tt_sequencer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/logic_tt_sequencer.sv
// Truth-table sequencer: walks every input vector of a combinational gate, checks each
// result against EXPECTED and reports pass/err_count/fail_index. Optional capture: TT_CAPTURE_EN.
module logic_tt_sequencer #(
    parameter int                   N_IN     = 2,
    parameter int                   SETTLE   = 1,
    parameter logic [2**N_IN-1:0]   EXPECTED = 4'b1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [N_IN-1:0]   gate_in,
    input  logic              gate_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IN:0]     err_count,
    output logic [N_IN-1:0]   fail_index
`ifdef TT_CAPTURE_EN
    ,
    output logic [2**N_IN-1:0] observed_tt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [3:0]      SETTLE_C = SETTLE[3:0];
    localparam logic [N_IN-1:0] LAST_V   = {N_IN{1'b1}};
    localparam logic [N_IN-1:0] ZERO_V   = {N_IN{1'b0}};
    localparam logic [N_IN:0]   ERR_ZERO = {(N_IN+1){1'b0}};
    localparam logic [N_IN:0]   ERR_MAX  = {1'b1, {N_IN{1'b0}}};

    state_t            state_q, state_d;
    logic [N_IN-1:0]   gate_in_q, gate_in_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [N_IN:0]     err_count_q, err_count_d;
    logic [N_IN-1:0]   fail_index_q, fail_index_d;
    logic              pass_q, pass_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [2**N_IN-1:0] obs_q, obs_d;

    logic              sample_s;
    logic              mismatch_s;
    logic              last_s;

    assign sample_s   = (state_q == ST_DRIVE) && (cnt_q == SETTLE_C);
    assign mismatch_s = (gate_out != EXPECTED[gate_in_q]);
    assign last_s     = (gate_in_q == LAST_V);

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            gate_in_q    <= ZERO_V;
            cnt_q        <= 4'd0;
            err_count_q  <= ERR_ZERO;
            fail_index_q <= ZERO_V;
            pass_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            obs_q        <= {(2**N_IN){1'b0}};
        end else begin
            state_q      <= state_d;
            gate_in_q    <= gate_in_d;
            cnt_q        <= cnt_d;
            err_count_q  <= err_count_d;
            fail_index_q <= fail_index_d;
            pass_q       <= pass_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            obs_q        <= obs_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_DRIVE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                if (sample_s && last_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRIVE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath and registered-output next values
    always_comb begin
        gate_in_d    = gate_in_q;
        cnt_d        = cnt_q;
        err_count_d  = err_count_q;
        fail_index_d = fail_index_q;
        pass_d       = pass_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        obs_d        = obs_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    gate_in_d    = ZERO_V;
                    cnt_d        = 4'd0;
                    err_count_d  = ERR_ZERO;
                    fail_index_d = ZERO_V;
                    pass_d       = 1'b0;
                    busy_d       = 1'b1;
                    obs_d        = {(2**N_IN){1'b0}};
                end else begin
                    busy_d = 1'b0;
                end
            end
            ST_DRIVE: begin
                if (sample_s) begin
                    obs_d[gate_in_q] = gate_out;
                    if (mismatch_s) begin
                        // Only the first mismatch of a run is recorded
                        if (err_count_q == ERR_ZERO) begin
                            fail_index_d = gate_in_q;
                        end else begin
                            fail_index_d = fail_index_q;
                        end
                        if (err_count_q != ERR_MAX) begin
                            err_count_d = err_count_q + {{N_IN{1'b0}}, 1'b1};
                        end else begin
                            err_count_d = err_count_q;
                        end
                    end else begin
                        err_count_d = err_count_q;
                    end
                    if (last_s) begin
                        busy_d = 1'b0;
                        done_d = 1'b1;
                        pass_d = (err_count_d == ERR_ZERO);
                    end else begin
                        gate_in_d = gate_in_q + N_IN'(1);
                        cnt_d     = 4'd0;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_DONE: begin
                busy_d = 1'b0;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    assign gate_in    = gate_in_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_count_q;
    assign fail_index = fail_index_q;
`ifdef TT_CAPTURE_EN
    assign observed_tt = obs_q;
`endif

endmodule
